// File: rtl/minutos_horas_ctrl.sv
// Minutes/hours stage of the clock: counts minute ticks, supports pause and a
// button-driven set mode with a blinking field, and drives four 7-segment digits.
module minutos_horas_ctrl #(
    parameter int BLINK_DIV   = 25_000_000,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clock,
    input  logic       ZERA,
    input  logic       min_tick,
    input  logic       pause_sw,
    input  logic       set_btn,
    input  logic       inc_btn,
    output logic [6:0] hex_min0,
    output logic [6:0] hex_min1,
    output logic [6:0] hex_hr0,
    output logic [6:0] hex_hr1,
    output logic       day_pulse,
    output logic [1:0] mode
);

    localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_PAUSE    = 2'd1,
        ST_SET_MIN  = 2'd2,
        ST_SET_HOUR = 2'd3
    } state_t;

    function automatic logic [6:0] seg7(input logic [5:0] d);
        case (d)
            6'd0:    seg7 = 7'b1000000;
            6'd1:    seg7 = 7'b1111001;
            6'd2:    seg7 = 7'b0100100;
            6'd3:    seg7 = 7'b0110000;
            6'd4:    seg7 = 7'b0011001;
            6'd5:    seg7 = 7'b0010010;
            6'd6:    seg7 = 7'b0000010;
            6'd7:    seg7 = 7'b1111000;
            6'd8:    seg7 = 7'b0000000;
            6'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'h7F;
        endcase
    endfunction

    // Button synchronizers with rising-edge detect. The edge detector stays
    // disarmed until the cleared chain has flushed, so a button held through
    // reset release does not register as a press.
    logic [1:0] btn_raw;
    logic [1:0] btn_edge;
    assign btn_raw = {inc_btn, set_btn};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_btn
            logic [SYNC_STAGES-1:0] sync_reg;
            logic [SYNC_STAGES-1:0] arm_reg;
            logic                   prev_reg;

            always_ff @(posedge clock or negedge ZERA) begin
                if (!ZERA) begin
                    sync_reg <= '0;
                    arm_reg  <= '0;
                    prev_reg <= 1'b1;
                end else begin
                    sync_reg <= {sync_reg[SYNC_STAGES-2:0], btn_raw[gi]};
                    arm_reg  <= {arm_reg[SYNC_STAGES-2:0], 1'b1};
                    prev_reg <= arm_reg[SYNC_STAGES-1] ? sync_reg[SYNC_STAGES-1] : 1'b1;
                end
            end

            assign btn_edge[gi] = sync_reg[SYNC_STAGES-1] & ~prev_reg;
        end
    endgenerate

    logic set_edge, inc_edge;
    assign set_edge = btn_edge[0];
    assign inc_edge = btn_edge[1];

    state_t          state_reg, state_next;
    logic [5:0]      min_reg, min_next;
    logic [4:0]      hour_reg, hour_next;
    logic [CW-1:0]   blink_cnt_reg, blink_cnt_next;
    logic            blink_ph_reg, blink_ph_next;
    logic            day_pulse_reg, day_pulse_next;
    logic [6:0]      hex_min0_reg, hex_min1_reg, hex_hr0_reg, hex_hr1_reg;
    logic [6:0]      hex_min0_next, hex_min1_next, hex_hr0_next, hex_hr1_next;
    logic [1:0]      mode_reg;

    always_comb begin
        state_next     = state_reg;
        min_next       = min_reg;
        hour_next      = hour_reg;
        blink_cnt_next = '0;
        blink_ph_next  = 1'b0;
        day_pulse_next = 1'b0;

        case (state_reg)
            ST_RUN, ST_PAUSE: begin
                if (state_reg == ST_RUN && min_tick) begin
                    if (min_reg == 6'd59) begin
                        min_next = 6'd0;
                        if (hour_reg == 5'd23) begin
                            hour_next      = 5'd0;
                            day_pulse_next = 1'b1;
                        end else begin
                            hour_next = hour_reg + 5'd1;
                        end
                    end else begin
                        min_next = min_reg + 6'd1;
                    end
                end
                if (set_edge)
                    state_next = ST_SET_MIN;
                else if (state_reg == ST_RUN && pause_sw)
                    state_next = ST_PAUSE;
                else if (state_reg == ST_PAUSE && !pause_sw)
                    state_next = ST_RUN;
            end
            ST_SET_MIN, ST_SET_HOUR: begin
                if (set_edge) begin
                    if (state_reg == ST_SET_MIN)
                        state_next = ST_SET_HOUR;
                    else
                        state_next = pause_sw ? ST_PAUSE : ST_RUN;
                end else if (inc_edge) begin
                    if (state_reg == ST_SET_MIN)
                        min_next = (min_reg == 6'd59) ? 6'd0 : min_reg + 6'd1;
                    else
                        hour_next = (hour_reg == 5'd23) ? 5'd0 : hour_reg + 5'd1;
                end else if (blink_cnt_reg == CW'(BLINK_DIV - 1)) begin
                    blink_ph_next = ~blink_ph_reg;
                end else begin
                    blink_cnt_next = blink_cnt_reg + CW'(1);
                    blink_ph_next  = blink_ph_reg;
                end
            end
            default: state_next = ST_RUN;
        endcase
    end

    logic [5:0] min_t, min_u;
    logic [4:0] hr_t, hr_u;
    logic       blank_min, blank_hr;

    always_comb begin
        min_t     = min_reg / 6'd10;
        min_u     = min_reg % 6'd10;
        hr_t      = hour_reg / 5'd10;
        hr_u      = hour_reg % 5'd10;
        blank_min = (state_reg == ST_SET_MIN) && blink_ph_reg;
        blank_hr  = (state_reg == ST_SET_HOUR) && blink_ph_reg;
        hex_min0_next = blank_min ? 7'h7F : seg7(min_u);
        hex_min1_next = blank_min ? 7'h7F : seg7(min_t);
        hex_hr0_next  = blank_hr  ? 7'h7F : seg7({1'b0, hr_u});
        hex_hr1_next  = blank_hr  ? 7'h7F : seg7({1'b0, hr_t});
    end

    always_ff @(posedge clock or negedge ZERA) begin
        if (!ZERA) begin
            state_reg     <= ST_RUN;
            min_reg       <= '0;
            hour_reg      <= '0;
            blink_cnt_reg <= '0;
            blink_ph_reg  <= 1'b0;
            day_pulse_reg <= 1'b0;
            hex_min0_reg  <= 7'b1000000;
            hex_min1_reg  <= 7'b1000000;
            hex_hr0_reg   <= 7'b1000000;
            hex_hr1_reg   <= 7'b1000000;
            mode_reg      <= 2'd0;
        end else begin
            state_reg     <= state_next;
            min_reg       <= min_next;
            hour_reg      <= hour_next;
            blink_cnt_reg <= blink_cnt_next;
            blink_ph_reg  <= blink_ph_next;
            day_pulse_reg <= day_pulse_next;
            hex_min0_reg  <= hex_min0_next;
            hex_min1_reg  <= hex_min1_next;
            hex_hr0_reg   <= hex_hr0_next;
            hex_hr1_reg   <= hex_hr1_next;
            mode_reg      <= state_reg;
        end
    end

    assign hex_min0  = hex_min0_reg;
    assign hex_min1  = hex_min1_reg;
    assign hex_hr0   = hex_hr0_reg;
    assign hex_hr1   = hex_hr1_reg;
    assign day_pulse = day_pulse_reg;
    assign mode      = mode_reg;

endmodule

// File: tb/tb_minutos_horas_ctrl.sv
// Scoreboard bench for minutos_horas_ctrl: expected display/mode values are
// queued as stimulus is applied and compared once the registered outputs settle.
module tb_minutos_horas_ctrl;

    logic       clock = 1'b0;
    logic       ZERA;
    logic       min_tick, pause_sw, set_btn, inc_btn;
    logic [6:0] hex_min0, hex_min1, hex_hr0, hex_hr1;
    logic       day_pulse;
    logic [1:0] mode;

    minutos_horas_ctrl #(.BLINK_DIV(4), .SYNC_STAGES(2)) dut (
        .clock    (clock),
        .ZERA     (ZERA),
        .min_tick (min_tick),
        .pause_sw (pause_sw),
        .set_btn  (set_btn),
        .inc_btn  (inc_btn),
        .hex_min0 (hex_min0),
        .hex_min1 (hex_min1),
        .hex_hr0  (hex_hr0),
        .hex_hr1  (hex_hr1),
        .day_pulse(day_pulse),
        .mode     (mode)
    );

    always #5 clock = ~clock;

    typedef struct {
        string      tag;
        int         sel;
        logic [6:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cur_min  = 0;
    int   cur_hour = 0;

    function automatic logic [6:0] seg(input int d);
        case (d)
            0: seg = 7'b1000000;
            1: seg = 7'b1111001;
            2: seg = 7'b0100100;
            3: seg = 7'b0110000;
            4: seg = 7'b0011001;
            5: seg = 7'b0010010;
            6: seg = 7'b0000010;
            7: seg = 7'b1111000;
            8: seg = 7'b0000000;
            default: seg = 7'b0010000;
        endcase
    endfunction

    function automatic logic [6:0] observe(input int sel);
        case (sel)
            0: observe = hex_min0;
            1: observe = hex_min1;
            2: observe = hex_hr0;
            3: observe = hex_hr1;
            4: observe = {5'b0, mode};
            default: observe = {6'b0, day_pulse};
        endcase
    endfunction

    task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
            $display("ok   %s: %b", tag, obs);
        end else begin
            $display("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input int sel, input logic [6:0] val);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = val;
        sb_q.push_back(e);
    endtask

    task automatic push_time(input string tag, input bit blank_min, input bit blank_hr);
        push({tag, "_min0"}, 0, blank_min ? 7'h7F : seg(cur_min % 10));
        push({tag, "_min1"}, 1, blank_min ? 7'h7F : seg(cur_min / 10));
        push({tag, "_hr0"},  2, blank_hr  ? 7'h7F : seg(cur_hour % 10));
        push({tag, "_hr1"},  3, blank_hr  ? 7'h7F : seg(cur_hour / 10));
    endtask

    task automatic push_mode(input string tag, input logic [1:0] m);
        push({tag, "_mode"}, 4, {5'b0, m});
    endtask

    task automatic drain();
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check(e.tag, observe(e.sel), e.val);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    // b: 0 = set, 1 = inc, 2 = both. Returns one cycle after the action,
    // when the registered outputs reflect it.
    task automatic press_hold(input int b);
        if (b != 1) set_btn = 1'b1;
        if (b != 0) inc_btn = 1'b1;
        cyc(4);
    endtask

    task automatic release_btns();
        set_btn = 1'b0;
        inc_btn = 1'b0;
        cyc(3);
    endtask

    task automatic press(input int b);
        press_hold(b);
        release_btns();
    endtask

    task automatic press_mode(input int b, input string tag, input logic [1:0] m);
        press_hold(b);
        push_mode(tag, m);
        drain();
        release_btns();
    endtask

    task automatic tick();
        min_tick = 1'b1;
        cyc(1);
        min_tick = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        ZERA = 1'b0; min_tick = 1'b0; pause_sw = 1'b0; set_btn = 1'b0; inc_btn = 1'b0;
        cyc(3);
        ZERA = 1'b1;
        cyc(1);

        // Reset state, then 60 minute ticks roll into 01:00
        push_time("rst", 0, 0);
        push_mode("rst", 2'd0);
        push("rst_day", 5, 7'd0);
        drain();
        for (int i = 0; i < 60; i++) begin
            tick();
            cyc(9);
        end
        cur_min = 0; cur_hour = 1;
        push_time("t1", 0, 0);
        push("t1_hr0_one", 2, 7'b1111001);
        push("t1_min0_zero", 0, 7'b1000000);
        push_mode("t1", 2'd0);
        drain();

        // Preload 23:59 through set mode, then wrap with a day pulse
        press_mode(0, "t2_setmin", 2'd2);
        repeat (59) press(1);
        cur_min = 59;
        press_mode(0, "t2_sethr", 2'd3);
        repeat (22) press(1);
        cur_hour = 23;
        press_hold(0);
        push_mode("t2_run", 2'd0);
        push_time("t2_2359", 0, 0);
        drain();
        release_btns();
        min_tick = 1'b1;
        cyc(1);
        min_tick = 1'b0;
        push("t2_day_hi", 5, 7'd1);
        drain();
        cyc(1);
        cur_min = 0; cur_hour = 0;
        push("t2_day_lo", 5, 7'd0);
        push_time("t2_0000", 0, 0);
        drain();

        // Ticks are dropped while paused
        pause_sw = 1'b1;
        cyc(2);
        push_mode("t3_pause", 2'd1);
        drain();
        for (int i = 0; i < 5; i++) begin
            tick();
            cyc(3);
        end
        push_time("t3_held", 0, 0);
        push_mode("t3_still", 2'd1);
        push("t3_day", 5, 7'd0);
        drain();
        pause_sw = 1'b0;
        cyc(2);
        push_mode("t3_run", 2'd0);
        push_time("t3_after", 0, 0);
        drain();

        // Preload 12:58, then minute adjust without hour carry
        press(0);
        repeat (58) press(1);
        press(0);
        repeat (12) press(1);
        press(0);
        cur_min = 58; cur_hour = 12;
        push_time("t4_1258", 0, 0);
        push_mode("t4_pre", 2'd0);
        drain();
        press_mode(0, "t4_setmin", 2'd2);
        for (int i = 0; i < 3; i++) begin
            press_hold(1);
            cur_min = (cur_min + 1) % 60;
            if (i == 2) begin
                push_time("t4_min01", 0, 0);
                drain();
            end
            release_btns();
        end
        press_mode(0, "t4_sethr", 2'd3);
        for (int i = 0; i < 11; i++) begin
            press(1);
            cur_hour = (cur_hour + 1) % 24;
        end
        press_hold(1);
        cur_hour = 0;

        // Blink with period 4: hour digits toggle, minutes stay visible
        for (int j = 0; j < 12; j++) begin
            push_time("t5_blink", 0, ((j / 4) % 2) == 1);
            drain();
            if (j < 11) cyc(1);
        end
        inc_btn = 1'b0;
        cyc(6);
        inc_btn = 1'b1;
        cyc(3);
        push_time("t5_pre_inc", 0, 1);
        drain();
        cyc(1);
        cur_hour = 1;
        push_time("t5_inc_vis", 0, 0);
        drain();
        release_btns();
        press_mode(0, "t4_back_run", 2'd0);
        push_time("t4_0101", 0, 0);
        drain();

        // set+inc together: set wins; then async reset mid-SET_HOUR with buttons held
        press_mode(0, "t6_setmin", 2'd2);
        press_hold(2);
        push_mode("t6_both", 2'd3);
        push_time("t6_min_kept", 0, 0);
        drain();
        @(negedge clock);
        #2 ZERA = 1'b0;
        #1;
        cur_min = 0; cur_hour = 0;
        push_time("t6_rst", 0, 0);
        push_mode("t6_rst", 2'd0);
        push("t6_rst_day", 5, 7'd0);
        drain();
        cyc(2);
        ZERA = 1'b1;
        cyc(10);
        push_time("t6_held", 0, 0);
        push_mode("t6_held", 2'd0);
        drain();
        release_btns();
        push_mode("t6_released", 2'd0);
        drain();
        press_mode(0, "t6_after", 2'd2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
